// File: rtl/tq_butterfly4_pipe.sv
// 4-point HEVC core-transform butterfly (forward/inverse DCT, coefficients 64/83/36), optional round-and-shift output.
// Latency: 3 cycles i_valid -> o_valid when un-stalled; throughput 1 beat/cycle.
// Backpressure: i_stall freezes every stage (data, valid, mode); beats presented while stalled are dropped.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset (clears every stage and the outputs)
//   i_valid, i_inverse     input beat valid, and its mode (0 = forward, 1 = inverse)
//   i_stall                hold the whole pipeline
//   i_d0..i_d3             signed IN_W samples (x0..x3 forward, y0..y3 inverse)
//   o_valid, o_inverse     output beat valid, and its mode
//   o_d0..o_d3             signed OUT_W results
module tq_butterfly4_pipe #(
    parameter int IN_W  = 16,
    parameter int SHIFT = 0,
    parameter int OUT_W = IN_W + 9 - SHIFT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_valid,
    input  logic                    i_stall,
    input  logic                    i_inverse,
    input  logic signed [IN_W-1:0]  i_d0,
    input  logic signed [IN_W-1:0]  i_d1,
    input  logic signed [IN_W-1:0]  i_d2,
    input  logic signed [IN_W-1:0]  i_d3,
    output logic                    o_valid,
    output logic                    o_inverse,
    output logic signed [OUT_W-1:0] o_d0,
    output logic signed [OUT_W-1:0] o_d1,
    output logic signed [OUT_W-1:0] o_d2,
    output logic signed [OUT_W-1:0] o_d3
);

    localparam int S1_W   = IN_W + 1;
    localparam int W2     = IN_W + 9;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [W2-1:0] RND = (SHIFT > 0) ? (W2'(1) <<< RND_SH) : '0;

    // Constant products as shift-add trees; operands are already W2 wide.
    function automatic logic signed [W2-1:0] mul64(input logic signed [W2-1:0] a);
        return a <<< 6;
    endfunction

    function automatic logic signed [W2-1:0] mul36(input logic signed [W2-1:0] a);
        return ((a <<< 3) + a) <<< 2;
    endfunction

    function automatic logic signed [W2-1:0] mul83(input logic signed [W2-1:0] a);
        return (a <<< 6) + a + (((a <<< 3) + a) <<< 1);
    endfunction

    function automatic logic signed [W2-1:0] ext2(input logic signed [S1_W-1:0] a);
        return W2'(a);
    endfunction

    // Round half up, then floor shift; the top bits are sign copies so truncation is lossless.
    function automatic logic signed [OUT_W-1:0] norm(input logic signed [W2-1:0] r);
        logic signed [W2-1:0] t;
        t = (r + RND) >>> SHIFT;
        return OUT_W'(t);
    endfunction

    // Stage 1: butterfly add (forward) or reorder into sum/odd paths (inverse).
    // Slot order: [0],[1] feed the 64 path, [2],[3] feed the 83/36 path.
    logic signed [S1_W-1:0] x0, x1, x2, x3;
    logic signed [S1_W-1:0] s1_d [4];
    logic signed [S1_W-1:0] s1_q [4];
    logic                   s1_vld_q, s1_inv_q;

    always_comb begin
        x0 = S1_W'(i_d0);
        x1 = S1_W'(i_d1);
        x2 = S1_W'(i_d2);
        x3 = S1_W'(i_d3);
        if (!i_inverse) begin
            s1_d[0] = x0 + x3;
            s1_d[1] = x1 + x2;
            s1_d[2] = x0 - x3;
            s1_d[3] = x1 - x2;
        end else begin
            s1_d[0] = x0;
            s1_d[1] = x2;
            s1_d[2] = x1;
            s1_d[3] = x3;
        end
    end

    // Stage 2: the six products are the same for both modes thanks to the slot ordering.
    logic signed [W2-1:0] s2_d [6];
    logic signed [W2-1:0] s2_q [6];
    logic                 s2_vld_q, s2_inv_q;

    always_comb begin
        s2_d[0] = mul64(ext2(s1_q[0]) + ext2(s1_q[1]));
        s2_d[1] = mul64(ext2(s1_q[0]) - ext2(s1_q[1]));
        s2_d[2] = mul83(ext2(s1_q[2]));
        s2_d[3] = mul36(ext2(s1_q[3]));
        s2_d[4] = mul36(ext2(s1_q[2]));
        s2_d[5] = mul83(ext2(s1_q[3]));
    end

    // Stage 3: combine; inverse adds the even and odd halves, forward passes them.
    logic signed [W2-1:0]    p_sum, q_sum;
    logic signed [W2-1:0]    r [4];
    logic signed [OUT_W-1:0] out_d [4];
    logic signed [OUT_W-1:0] out_q [4];
    logic                    out_vld_q, out_inv_q;

    always_comb begin
        p_sum = s2_q[2] + s2_q[3];
        q_sum = s2_q[4] - s2_q[5];
        if (!s2_inv_q) begin
            r[0] = s2_q[0];
            r[1] = p_sum;
            r[2] = s2_q[1];
            r[3] = q_sum;
        end else begin
            r[0] = s2_q[0] + p_sum;
            r[1] = s2_q[1] + q_sum;
            r[2] = s2_q[1] - q_sum;
            r[3] = s2_q[0] - p_sum;
        end
        for (int k = 0; k < 4; k++) begin
            out_d[k] = norm(r[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_inv_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_inv_q  <= 1'b0;
            out_vld_q <= 1'b0;
            out_inv_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                s1_q[k]  <= '0;
                out_q[k] <= '0;
            end
            for (int k = 0; k < 6; k++) begin
                s2_q[k] <= '0;
            end
        end else if (!i_stall) begin
            s1_vld_q  <= i_valid;
            s1_inv_q  <= i_inverse;
            s2_vld_q  <= s1_vld_q;
            s2_inv_q  <= s1_inv_q;
            out_vld_q <= s2_vld_q;
            out_inv_q <= s2_inv_q;
            for (int k = 0; k < 4; k++) begin
                s1_q[k]  <= s1_d[k];
                out_q[k] <= out_d[k];
            end
            for (int k = 0; k < 6; k++) begin
                s2_q[k] <= s2_d[k];
            end
        end
    end

    assign o_valid   = out_vld_q;
    assign o_inverse = out_inv_q;
    assign o_d0      = out_q[0];
    assign o_d1      = out_q[1];
    assign o_d2      = out_q[2];
    assign o_d3      = out_q[3];

endmodule

// File: tb/tb_tq_butterfly4_pipe.sv
// Bench for tq_butterfly4_pipe: three instances (SHIFT 0, 2, 7) share one input stream.
// Expected results are pushed per accepted beat and popped when the outputs advance.
// Stall cycles freeze the outputs, so nothing is popped on an edge taken while stalled.
module tb_tq_butterfly4_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_valid = 1'b0;
    logic i_stall = 1'b0;
    logic i_inverse = 1'b0;
    logic signed [15:0] i_d0 = '0, i_d1 = '0, i_d2 = '0, i_d3 = '0;

    logic o_valid_a, o_inverse_a, o_valid_b, o_inverse_b, o_valid_c, o_inverse_c;
    logic signed [24:0] oa0, oa1, oa2, oa3;
    logic signed [22:0] ob0, ob1, ob2, ob3;
    logic signed [17:0] oc0, oc1, oc2, oc3;

    tq_butterfly4_pipe #(.IN_W(16), .SHIFT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_stall(i_stall), .i_inverse(i_inverse),
        .i_d0(i_d0), .i_d1(i_d1), .i_d2(i_d2), .i_d3(i_d3),
        .o_valid(o_valid_a), .o_inverse(o_inverse_a), .o_d0(oa0), .o_d1(oa1), .o_d2(oa2), .o_d3(oa3));

    tq_butterfly4_pipe #(.IN_W(16), .SHIFT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_stall(i_stall), .i_inverse(i_inverse),
        .i_d0(i_d0), .i_d1(i_d1), .i_d2(i_d2), .i_d3(i_d3),
        .o_valid(o_valid_b), .o_inverse(o_inverse_b), .o_d0(ob0), .o_d1(ob1), .o_d2(ob2), .o_d3(ob3));

    tq_butterfly4_pipe #(.IN_W(16), .SHIFT(7)) dut_c (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_stall(i_stall), .i_inverse(i_inverse),
        .i_d0(i_d0), .i_d1(i_d1), .i_d2(i_d2), .i_d3(i_d3),
        .o_valid(o_valid_c), .o_inverse(o_inverse_c), .o_d0(oc0), .o_d1(oc1), .o_d2(oc2), .o_d3(oc3));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic                   inv;
        logic [2:0][3:0][31:0]  d;
    } exp_t;

    exp_t sbq[$];
    int   n_acc = 0;
    int   n_out = 0;
    logic adv = 1'b0;

    int   got [3][4];
    logic vld [3];
    logic inv_o [3];

    always_comb begin
        got[0][0] = int'(oa0); got[0][1] = int'(oa1); got[0][2] = int'(oa2); got[0][3] = int'(oa3);
        got[1][0] = int'(ob0); got[1][1] = int'(ob1); got[1][2] = int'(ob2); got[1][3] = int'(ob3);
        got[2][0] = int'(oc0); got[2][1] = int'(oc1); got[2][2] = int'(oc2); got[2][3] = int'(oc3);
        vld[0] = o_valid_a;   vld[1] = o_valid_b;   vld[2] = o_valid_c;
        inv_o[0] = o_inverse_a; inv_o[1] = o_inverse_b; inv_o[2] = o_inverse_c;
    end

    // Reference transform written directly from the matrix form, using plain multiplies.
    function automatic int ref_r(input int k, input logic inv, input int a, input int b, input int c, input int d);
        if (!inv) begin
            case (k)
                0: return 64 * (a + b + c + d);
                1: return 83 * (a - d) + 36 * (b - c);
                2: return 64 * (a + d - b - c);
                default: return 36 * (a - d) - 83 * (b - c);
            endcase
        end else begin
            case (k)
                0: return 64 * (a + c) + 83 * b + 36 * d;
                1: return 64 * (a - c) + 36 * b - 83 * d;
                2: return 64 * (a - c) - 36 * b + 83 * d;
                default: return 64 * (a + c) - 83 * b - 36 * d;
            endcase
        end
    endfunction

    function automatic int norm(input int r, input int sh);
        if (sh == 0) return r;
        return (r + (1 << (sh - 1))) >>> sh;
    endfunction

    function automatic int sh_of(input int k);
        case (k)
            0: return 0;
            1: return 2;
            default: return 7;
        endcase
    endfunction

    always @(posedge clk) begin
        exp_t e;
        adv = rst_n && !i_stall;
        if (rst_n && !i_stall && i_valid) begin
            e.inv = i_inverse;
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j < 4; j++) begin
                    e.d[k][j] = 32'(norm(ref_r(j, i_inverse, int'(i_d0), int'(i_d1), int'(i_d2), int'(i_d3)), sh_of(k)));
                end
            end
            sbq.push_back(e);
            n_acc++;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        logic bad;
        if (adv && rst_n && vld[0]) begin
            n_out++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: output beat with nothing expected, got d0=%0d", got[0][0]);
            end else begin
                e = sbq.pop_front();
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    bad = (vld[k] !== 1'b1) || (inv_o[k] !== e.inv);
                    for (int j = 0; j < 4; j++) begin
                        if (got[k][j] != int'(e.d[k][j])) bad = 1'b1;
                    end
                    if (bad) begin
                        errors++;
                        $display("FAIL sb_beat shift=%0d: got v=%0b inv=%0b d=(%0d,%0d,%0d,%0d) want v=1 inv=%0b d=(%0d,%0d,%0d,%0d)",
                                 sh_of(k), vld[k], inv_o[k], got[k][0], got[k][1], got[k][2], got[k][3],
                                 e.inv, int'(e.d[k][0]), int'(e.d[k][1]), int'(e.d[k][2]), int'(e.d[k][3]));
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic inv, input int a, input int b, input int c, input int d);
        @(posedge clk);
        #1;
        i_valid   = v;
        i_inverse = inv;
        i_d0 = 16'(a); i_d1 = 16'(b); i_d2 = 16'(c); i_d3 = 16'(d);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            i_valid = 1'b0;
        end
    endtask

    // Counts edges (the first is the acceptance edge) until instance A shows o_valid.
    task automatic wait_out(output int lat);
        lat = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            i_valid = 1'b0;
            if (o_valid_a) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat;
        logic bad;
        #2;
        for (int k = 0; k < 3; k++) begin
            checks++;
            bad = (vld[k] !== 1'b0) || (inv_o[k] !== 1'b0);
            for (int j = 0; j < 4; j++) if (got[k][j] != 0) bad = 1'b1;
            if (bad) begin
                errors++;
                $display("FAIL reset_state shift=%0d: got v=%0b d0=%0d want all zero", sh_of(k), vld[k], got[k][0]);
            end
        end
        @(posedge clk); #1; rst_n = 1'b1;
        idle(2);
        drive(1'b1, 1'b0, 100, -7, 33, 5);
        drive(1'b1, 1'b1, -9, 44, 12, -300);
        drive(1'b1, 1'b0, 7, 7, -7, 7);
        @(posedge clk);
        #3;
        checks++;
        if (o_valid_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_inflight_pre: got o_valid=%0b want 1", o_valid_a);
        end
        rst_n = 1'b0;
        i_valid = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            bad = (vld[k] !== 1'b0) || (inv_o[k] !== 1'b0);
            for (int j = 0; j < 4; j++) if (got[k][j] != 0) bad = 1'b1;
            if (bad) begin
                errors++;
                $display("FAIL reset_async shift=%0d: got v=%0b d0=%0d want all zero", sh_of(k), vld[k], got[k][0]);
            end
        end
        sbq.delete();
        idle(2);
        rst_n = 1'b1;
        idle(2);
        checks++;
        if (o_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_partial: got o_valid=%0b want 0", o_valid_a);
        end
        drive(1'b1, 1'b1, 5, -6, 7, -8);
        wait_out(lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL reset_first_latency: got %0d want 3", lat);
        end
        idle(2);
    endtask

    task automatic test_forward();
        int lat;
        int want [4] = '{640, -285, 0, -25};
        drive(1'b1, 1'b0, 1, 2, 3, 4);
        wait_out(lat);
        checks++;
        if (lat !== 3 || o_inverse_a !== 1'b0) begin
            errors++;
            $display("FAIL fwd_latency_mode: got lat=%0d inv=%0b want lat=3 inv=0", lat, o_inverse_a);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (got[0][j] != want[j]) begin
                errors++;
                $display("FAIL fwd_d%0d: got %0d want %0d", j, got[0][j], want[j]);
            end
        end
        idle(2);
    endtask

    task automatic test_inverse_round();
        int lat;
        int want_a [4] = '{32, 32, 32, 32};
        int want_b [4] = '{42, 18, -18, -41};
        drive(1'b1, 1'b1, 64, 0, 0, 0);
        wait_out(lat);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (got[2][j] != want_a[j] || o_inverse_c !== 1'b1) begin
                errors++;
                $display("FAIL inv_dc_d%0d: got %0d inv=%0b want %0d inv=1", j, got[2][j], o_inverse_c, want_a[j]);
            end
        end
        drive(1'b1, 1'b1, 0, 64, 0, 0);
        wait_out(lat);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (got[2][j] != want_b[j]) begin
                errors++;
                $display("FAIL inv_floor_d%0d: got %0d want %0d", j, got[2][j], want_b[j]);
            end
        end
        idle(2);
    endtask

    task automatic test_extremes();
        int lat;
        int want1 [4] = '{-5734436, -3899309, 3899309, -2654172};
        int want2 [4] = '{5734189, 3899356, -3899356, 2654163};
        drive(1'b1, 1'b1, -32768, -32768, -32768, 32767);
        wait_out(lat);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (got[0][j] != want1[j]) begin
                errors++;
                $display("FAIL ext_neg_d%0d: got %0d want %0d", j, got[0][j], want1[j]);
            end
        end
        drive(1'b1, 1'b1, 32767, 32767, 32767, -32768);
        wait_out(lat);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (got[0][j] != want2[j]) begin
                errors++;
                $display("FAIL ext_pos_d%0d: got %0d want %0d", j, got[0][j], want2[j]);
            end
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        int acc0 = n_acc;
        int out0 = n_out;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 1'(i & 1),
                  int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
        end
        idle(6);
        checks++;
        if ((n_acc - acc0) != 100 || (n_out - out0) != 100 || sbq.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got in=%0d out=%0d pending=%0d want 100/100/0",
                     n_acc - acc0, n_out - out0, sbq.size());
        end
    endtask

    task automatic test_stall();
        int   lat;
        int   acc0 = n_acc;
        int   out0 = n_out;
        int   hold_d [4];
        logic hold_v;
        logic bad;
        drive(1'b1, 1'b0, 1000, -2000, 300, 44);     // Z: reaches the output just before the stall
        drive(1'b1, 1'b1, -123, 456, -789, 1011);    // A
        drive(1'b1, 1'b0, 17, -17, 2500, -31000);    // B (A accepted on this edge: count 1)
        @(posedge clk);                               // B accepted: count 2
        #1;
        i_stall = 1'b1;
        i_valid = 1'b1;
        i_inverse = 1'b1;
        i_d0 = 16'sd9999; i_d1 = -16'sd9999; i_d2 = 16'sd1; i_d3 = 16'sd2;
        hold_v = o_valid_a;
        for (int j = 0; j < 4; j++) hold_d[j] = got[0][j];
        checks++;
        if (hold_v !== 1'b1) begin
            errors++;
            $display("FAIL stall_pre_valid: got o_valid=%0b want 1", hold_v);
        end
        for (int s = 0; s < 4; s++) begin
            @(posedge clk);
            #1;
            checks++;
            bad = (o_valid_a !== hold_v);
            for (int j = 0; j < 4; j++) if (got[0][j] != hold_d[j]) bad = 1'b1;
            if (bad) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got v=%0b d0=%0d want v=%0b d0=%0d",
                         s, o_valid_a, got[0][0], hold_v, hold_d[0]);
            end
        end
        i_stall = 1'b0;
        i_valid = 1'b0;
        lat = -1;
        for (int c = 7; c <= 16; c++) begin
            @(posedge clk);
            #1;
            if (o_valid_a) begin
                lat = c;
                break;
            end
        end
        checks++;
        if (lat !== 7) begin
            errors++;
            $display("FAIL stall_latency: got %0d want 7", lat);
        end
        idle(5);
        checks++;
        if ((n_acc - acc0) != 3 || (n_out - out0) != 3 || sbq.size() != 0) begin
            errors++;
            $display("FAIL stall_count: got in=%0d out=%0d pending=%0d want 3/3/0",
                     n_acc - acc0, n_out - out0, sbq.size());
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse_round();
        test_extremes();
        test_back_to_back();
        test_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
